// File: rtl/ccpd_scan_ctrl.sv
// CCPD pixel scan controller: walks an inclusive pixel range, loading each pixel
// configuration over SPI and firing a fixed number of injection sequences per pixel.
module ccpd_scan_ctrl #(
    parameter int PIX_BITS = 8,
    parameter int REP_BITS = 16,
    parameter int TIMEOUT  = 65535
) (
    input  logic                BUS_CLK,
    input  logic                BUS_RST,
    input  logic                START,
    input  logic                ABORT,
    input  logic [PIX_BITS-1:0] PIX_FIRST,
    input  logic [PIX_BITS-1:0] PIX_LAST,
    input  logic [REP_BITS-1:0] REPEAT,
    input  logic [15:0]         SETTLE,
    output logic                CONF_START,
    input  logic                CONF_READY,
    output logic                SEQ_START,
    input  logic                SEQ_READY,
    input  logic                FIFO_NEAR_FULL,
    output logic [PIX_BITS-1:0] PIX_ADDR,
    output logic [REP_BITS-1:0] INJ_CNT,
    output logic                BUSY,
    output logic                DONE,
    output logic                ABORTED,
    output logic                TIMEOUT_ERR
);

    localparam int WAIT_BITS = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CONF, S_CONF_WAIT, S_SETTLE, S_INJ_HOLD,
        S_INJ, S_INJ_WAIT, S_NEXT, S_FINISH
    } state_t;

    state_t               state, state_next;
    logic [PIX_BITS-1:0]  last_q;
    logic [REP_BITS-1:0]  rep_q;
    logic [15:0]          settle_q;
    logic [15:0]          settle_cnt;
    logic [WAIT_BITS-1:0] wait_cnt;
    logic [REP_BITS-1:0]  inj_next;
    logic                 wait_first;
    logic                 wait_expired;

    assign inj_next     = INJ_CNT + REP_BITS'(1);
    // First wait cycle is the handshake turnaround: the ready level still reflects the previous job.
    assign wait_first   = (wait_cnt == '0);
    assign wait_expired = (wait_cnt == WAIT_BITS'(TIMEOUT - 1));

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) state <= S_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (START) state_next = S_CONF;
            S_CONF:      state_next = S_CONF_WAIT;
            S_CONF_WAIT: begin
                if (!wait_first && CONF_READY) state_next = S_SETTLE;
                else if (wait_expired)         state_next = S_IDLE;
            end
            S_SETTLE:    if (settle_cnt == '0) state_next = S_INJ_HOLD;
            S_INJ_HOLD:  if (!FIFO_NEAR_FULL && SEQ_READY) state_next = S_INJ;
            S_INJ:       state_next = S_INJ_WAIT;
            S_INJ_WAIT: begin
                if (!wait_first && SEQ_READY) state_next = (inj_next < rep_q) ? S_INJ_HOLD : S_NEXT;
                else if (wait_expired)        state_next = S_IDLE;
            end
            S_NEXT:      state_next = (PIX_ADDR == last_q) ? S_FINISH : S_CONF;
            S_FINISH:    state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
        if (ABORT) state_next = S_IDLE;
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            CONF_START  <= 1'b0;
            SEQ_START   <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            ABORTED     <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            PIX_ADDR    <= '0;
            INJ_CNT     <= '0;
            last_q      <= '0;
            rep_q       <= '0;
            settle_q    <= '0;
            settle_cnt  <= '0;
            wait_cnt    <= '0;
        end else begin
            // Pulses are decoded from the next state so they appear registered for the single cycle spent in CONF/INJ.
            CONF_START <= (state_next == S_CONF);
            SEQ_START  <= (state_next == S_INJ);
            BUSY       <= (state_next != S_IDLE);

            if (state_next != state)
                wait_cnt <= '0;
            else if (state == S_CONF_WAIT || state == S_INJ_WAIT)
                wait_cnt <= wait_cnt + WAIT_BITS'(1);

            if (ABORT) begin
                ABORTED <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: if (START) begin
                        last_q      <= PIX_LAST;
                        rep_q       <= (REPEAT == '0) ? REP_BITS'(1) : REPEAT;
                        settle_q    <= SETTLE;
                        PIX_ADDR    <= PIX_FIRST;
                        INJ_CNT     <= '0;
                        DONE        <= 1'b0;
                        ABORTED     <= 1'b0;
                        TIMEOUT_ERR <= 1'b0;
                    end
                    S_CONF_WAIT: begin
                        if (!wait_first && CONF_READY) settle_cnt <= settle_q;
                        else if (wait_expired)         TIMEOUT_ERR <= 1'b1;
                    end
                    S_SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - 16'd1;
                    S_INJ_WAIT: begin
                        if (!wait_first && SEQ_READY) INJ_CNT <= inj_next;
                        else if (wait_expired)        TIMEOUT_ERR <= 1'b1;
                    end
                    S_NEXT: if (PIX_ADDR != last_q) begin
                        PIX_ADDR <= PIX_ADDR + PIX_BITS'(1);
                        INJ_CNT  <= '0;
                    end
                    S_FINISH: DONE <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ccpd_scan_ctrl.sv
// Directed bench for ccpd_scan_ctrl: ready responders answer each pulse after three cycles,
// a negedge monitor logs pulses and the pixel address seen with every CONF_START.
module tb_ccpd_scan_ctrl;

    logic        BUS_CLK, BUS_RST, START, ABORT;
    logic [7:0]  PIX_FIRST, PIX_LAST, PIX_ADDR;
    logic [15:0] REPEAT, SETTLE, INJ_CNT;
    logic        CONF_START, CONF_READY, SEQ_START, SEQ_READY, FIFO_NEAR_FULL;
    logic        BUSY, DONE, ABORTED, TIMEOUT_ERR;

    int n_cmp = 0;
    int n_err = 0;
    int conf_total = 0;
    int seq_total = 0;
    int overlap_total = 0;
    int pix_log[$];
    bit seq_hang = 0;

    ccpd_scan_ctrl #(.PIX_BITS(8), .REP_BITS(16), .TIMEOUT(50)) dut (
        .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .START(START), .ABORT(ABORT),
        .PIX_FIRST(PIX_FIRST), .PIX_LAST(PIX_LAST), .REPEAT(REPEAT), .SETTLE(SETTLE),
        .CONF_START(CONF_START), .CONF_READY(CONF_READY),
        .SEQ_START(SEQ_START), .SEQ_READY(SEQ_READY), .FIFO_NEAR_FULL(FIFO_NEAR_FULL),
        .PIX_ADDR(PIX_ADDR), .INJ_CNT(INJ_CNT), .BUSY(BUSY), .DONE(DONE),
        .ABORTED(ABORTED), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    initial begin
        BUS_CLK = 0;
        forever #5 BUS_CLK = ~BUS_CLK;
    end

    initial begin
        forever begin
            @(negedge BUS_CLK);
            if (CONF_START === 1'b1) begin
                conf_total++;
                pix_log.push_back(int'(PIX_ADDR));
            end
            if (SEQ_START === 1'b1) seq_total++;
            if (CONF_START === 1'b1 && SEQ_START === 1'b1) overlap_total++;
        end
    end

    initial begin
        CONF_READY = 1;
        forever begin
            @(negedge BUS_CLK);
            if (CONF_START === 1'b1) begin
                CONF_READY = 0;
                repeat (3) @(negedge BUS_CLK);
                CONF_READY = 1;
            end
        end
    end

    initial begin
        SEQ_READY = 1;
        forever begin
            @(negedge BUS_CLK);
            if (SEQ_START === 1'b1) begin
                SEQ_READY = 0;
                repeat (3) @(negedge BUS_CLK);
                while (seq_hang) @(negedge BUS_CLK);
                SEQ_READY = 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    task automatic start_scan(input logic [7:0] first, input logic [7:0] last,
                              input logic [15:0] rep, input logic [15:0] settle);
        @(negedge BUS_CLK);
        PIX_FIRST = first;
        PIX_LAST  = last;
        REPEAT    = rep;
        SETTLE    = settle;
        START     = 1;
        @(negedge BUS_CLK);
        START     = 0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge BUS_CLK);
            if (BUSY === 1'b0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_seq_start(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge BUS_CLK);
            if (SEQ_START === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        BUS_RST = 1; START = 1; ABORT = 0; FIFO_NEAR_FULL = 0;
        PIX_FIRST = 8'd9; PIX_LAST = 8'd9; REPEAT = 16'd1; SETTLE = 16'd0;
        repeat (3) @(negedge BUS_CLK);
        n_cmp++;
        if ({CONF_START, SEQ_START, BUSY, DONE, ABORTED, TIMEOUT_ERR} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b, want 000000",
                     {CONF_START, SEQ_START, BUSY, DONE, ABORTED, TIMEOUT_ERR});
        end
        n_cmp++;
        if (PIX_ADDR !== 8'd0 || INJ_CNT !== 16'd0) begin
            n_err++;
            $display("FAIL reset_counts: got pix=%0d inj=%0d, want 0/0", PIX_ADDR, INJ_CNT);
        end
        BUS_RST = 0; START = 0;
        @(negedge BUS_CLK);
        n_cmp++;
        if (BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_idle: got busy=%b, want 0", BUSY);
        end
    endtask

    task automatic test_basic_scan();
        int c0, s0, p0;
        bit ok;
        int exp_pix[3] = '{2, 3, 4};
        c0 = conf_total; s0 = seq_total; p0 = pix_log.size();
        start_scan(8'd2, 8'd4, 16'd3, 16'd5);
        n_cmp++;
        if (BUSY !== 1'b1) begin
            n_err++;
            $display("FAIL basic_busy: got %b, want 1", BUSY);
        end
        wait_idle(2000, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL basic_complete: got still busy, want idle within 2000 cycles");
        end
        n_cmp++;
        if (conf_total - c0 !== 3 || seq_total - s0 !== 9) begin
            n_err++;
            $display("FAIL basic_pulses: got conf=%0d seq=%0d, want 3/9", conf_total - c0, seq_total - s0);
        end
        n_cmp++;
        if (pix_log.size() - p0 !== 3) begin
            n_err++;
            $display("FAIL basic_pix_count: got %0d, want 3", pix_log.size() - p0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (pix_log[p0 + i] !== exp_pix[i]) begin
                    n_err++;
                    $display("FAIL basic_pix_seq[%0d]: got %0d, want %0d", i, pix_log[p0 + i], exp_pix[i]);
                end
            end
        end
        n_cmp++;
        if ({DONE, BUSY, ABORTED, TIMEOUT_ERR} !== 4'b1000) begin
            n_err++;
            $display("FAIL basic_status: got done/busy/abort/tmo=%b, want 1000",
                     {DONE, BUSY, ABORTED, TIMEOUT_ERR});
        end
        n_cmp++;
        if (INJ_CNT !== 16'd3 || PIX_ADDR !== 8'd4) begin
            n_err++;
            $display("FAIL basic_final_regs: got inj=%0d pix=%0d, want 3/4", INJ_CNT, PIX_ADDR);
        end
    endtask

    task automatic test_repeat_zero();
        int c0, s0;
        bit ok;
        c0 = conf_total; s0 = seq_total;
        start_scan(8'd7, 8'd7, 16'd0, 16'd0);
        wait_idle(500, ok);
        n_cmp++;
        if (!ok || conf_total - c0 !== 1 || seq_total - s0 !== 1) begin
            n_err++;
            $display("FAIL rep0_pulses: got ok=%0d conf=%0d seq=%0d, want 1/1/1", ok, conf_total - c0, seq_total - s0);
        end
        n_cmp++;
        if (DONE !== 1'b1 || INJ_CNT !== 16'd1 || PIX_ADDR !== 8'd7) begin
            n_err++;
            $display("FAIL rep0_final: got done=%b inj=%0d pix=%0d, want 1/1/7", DONE, INJ_CNT, PIX_ADDR);
        end
    endtask

    task automatic test_start_while_busy();
        int c0, p0;
        bit ok;
        c0 = conf_total; p0 = pix_log.size();
        start_scan(8'd20, 8'd21, 16'd1, 16'd0);
        repeat (3) @(negedge BUS_CLK);
        PIX_FIRST = 8'd100; PIX_LAST = 8'd100; START = 1;
        @(negedge BUS_CLK);
        START = 0;
        wait_idle(500, ok);
        n_cmp++;
        if (!ok || conf_total - c0 !== 2 || pix_log.size() - p0 !== 2) begin
            n_err++;
            $display("FAIL busy_start_count: got ok=%0d conf=%0d, want 1/2", ok, conf_total - c0);
        end else begin
            n_cmp++;
            if (pix_log[p0] !== 20 || pix_log[p0 + 1] !== 21) begin
                n_err++;
                $display("FAIL busy_start_pix: got %0d,%0d, want 20,21", pix_log[p0], pix_log[p0 + 1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int s0;
        bit tmo_seen, ok;
        FIFO_NEAR_FULL = 1;
        start_scan(8'd10, 8'd10, 16'd1, 16'd0);
        repeat (10) @(negedge BUS_CLK);
        s0 = seq_total;
        tmo_seen = 0;
        repeat (100) begin
            @(negedge BUS_CLK);
            if (TIMEOUT_ERR === 1'b1) tmo_seen = 1;
        end
        n_cmp++;
        if (seq_total - s0 !== 0 || tmo_seen || BUSY !== 1'b1) begin
            n_err++;
            $display("FAIL hold_blocked: got seq=%0d tmo=%0d busy=%b, want 0/0/1", seq_total - s0, tmo_seen, BUSY);
        end
        FIFO_NEAR_FULL = 0;
        @(negedge BUS_CLK);
        n_cmp++;
        if (SEQ_START !== 1'b1) begin
            n_err++;
            $display("FAIL hold_release: got seq_start=%b one cycle after release, want 1", SEQ_START);
        end
        wait_idle(500, ok);
        n_cmp++;
        if (!ok || DONE !== 1'b1) begin
            n_err++;
            $display("FAIL hold_done: got ok=%0d done=%b, want 1/1", ok, DONE);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        bit ok;
        seq_hang = 1;
        start_scan(8'd3, 8'd3, 16'd1, 16'd0);
        wait_seq_start(200, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL tmo_seq_start: got none, want SEQ_START within 200 cycles");
        end
        cyc = 0;
        do begin
            @(negedge BUS_CLK);
            cyc++;
        end while (BUSY === 1'b1 && cyc < 200);
        n_cmp++;
        if (cyc !== 51) begin
            n_err++;
            $display("FAIL tmo_cycles: got idle after %0d cycles, want 51", cyc);
        end
        n_cmp++;
        if ({TIMEOUT_ERR, DONE, BUSY} !== 3'b100) begin
            n_err++;
            $display("FAIL tmo_status: got tmo/done/busy=%b, want 100", {TIMEOUT_ERR, DONE, BUSY});
        end
        seq_hang = 0;
        repeat (5) @(negedge BUS_CLK);
    endtask

    task automatic test_wrap();
        int p0;
        bit ok;
        int exp_pix[4] = '{254, 255, 0, 1};
        p0 = pix_log.size();
        start_scan(8'd254, 8'd1, 16'd1, 16'd2);
        wait_idle(1000, ok);
        n_cmp++;
        if (!ok || pix_log.size() - p0 !== 4 || DONE !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_count: got ok=%0d pixels=%0d done=%b, want 1/4/1", ok, pix_log.size() - p0, DONE);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (pix_log[p0 + i] !== exp_pix[i]) begin
                    n_err++;
                    $display("FAIL wrap_pix_seq[%0d]: got %0d, want %0d", i, pix_log[p0 + i], exp_pix[i]);
                end
            end
        end
    endtask

    task automatic test_abort_and_reset();
        int c0, s0;
        bit ok;
        start_scan(8'd5, 8'd6, 16'd2, 16'd0);
        wait_seq_start(200, ok);
        @(negedge BUS_CLK);
        c0 = conf_total; s0 = seq_total;
        ABORT = 1; START = 1; PIX_FIRST = 8'd99;
        @(negedge BUS_CLK);
        ABORT = 0; START = 0;
        n_cmp++;
        if (!ok || {BUSY, ABORTED, DONE, CONF_START, SEQ_START} !== 5'b01000) begin
            n_err++;
            $display("FAIL abort_status: got ok=%0d busy/abort/done/cs/ss=%b, want 1/01000",
                     ok, {BUSY, ABORTED, DONE, CONF_START, SEQ_START});
        end
        repeat (6) @(negedge BUS_CLK);
        n_cmp++;
        if (conf_total - c0 !== 0 || seq_total - s0 !== 0 || BUSY !== 1'b0 || ABORTED !== 1'b1) begin
            n_err++;
            $display("FAIL abort_quiet: got conf=%0d seq=%0d busy=%b aborted=%b, want 0/0/0/1",
                     conf_total - c0, seq_total - s0, BUSY, ABORTED);
        end
        start_scan(8'd5, 8'd5, 16'd1, 16'd0);
        n_cmp++;
        if (ABORTED !== 1'b0 || BUSY !== 1'b1) begin
            n_err++;
            $display("FAIL abort_clear_on_start: got aborted=%b busy=%b, want 0/1", ABORTED, BUSY);
        end
        wait_seq_start(200, ok);
        @(negedge BUS_CLK);
        c0 = conf_total; s0 = seq_total;
        BUS_RST = 1; START = 1;
        @(negedge BUS_CLK);
        n_cmp++;
        if (!ok || {CONF_START, SEQ_START, BUSY, DONE, ABORTED, TIMEOUT_ERR} !== 6'b0
            || PIX_ADDR !== 8'd0 || INJ_CNT !== 16'd0) begin
            n_err++;
            $display("FAIL midscan_reset: got ok=%0d flags=%b pix=%0d inj=%0d, want 1/000000/0/0",
                     ok, {CONF_START, SEQ_START, BUSY, DONE, ABORTED, TIMEOUT_ERR}, PIX_ADDR, INJ_CNT);
        end
        repeat (3) @(negedge BUS_CLK);
        BUS_RST = 0; START = 0;
        @(negedge BUS_CLK);
        n_cmp++;
        if (conf_total - c0 !== 0 || seq_total - s0 !== 0 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL reset_quiet: got conf=%0d seq=%0d busy=%b, want 0/0/0", conf_total - c0, seq_total - s0, BUSY);
        end
    endtask

    task automatic test_no_overlap();
        n_cmp++;
        if (overlap_total !== 0) begin
            n_err++;
            $display("FAIL pulse_overlap: got %0d overlapping cycles, want 0", overlap_total);
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_repeat_zero();
        test_start_while_busy();
        test_backpressure();
        test_timeout();
        test_wrap();
        test_abort_and_reset();
        test_no_overlap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
